// File: rtl/store_merge.sv
// Sub-word store engine: word stores write straight through, half/byte stores read-modify-write the containing word.
// Latency: word 2 cycles, half/byte 4 cycles, misaligned 1 cycle to done; req is ignored while busy.
module store_merge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        SC_CS,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, READ, RDWAIT, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_mis;
  logic [31:0]       r_merged;

  logic              w_in_half;
  logic              w_in_byte;
  logic              w_in_mis;
  logic              w_rmw;
  logic [ADDR_W-1:0] w_addr_al;
  logic [31:0]       w_merged;

  // Size 2'b11 falls into the word path, so it shares the word alignment rule.
  assign w_in_half = (SC_CS == SZ_HALF);
  assign w_in_byte = (SC_CS == SZ_BYTE);
  assign w_in_mis  = (w_in_half && addr[0]) ||
                     (!w_in_half && !w_in_byte && (addr[1:0] != 2'b00));

  assign w_rmw     = (r_size == SZ_HALF) || (r_size == SZ_BYTE);
  assign w_addr_al = {r_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_size == SZ_HALF) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_mis    <= 1'b0;
      r_merged <= '0;
    end else begin
      if (r_state == IDLE && req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_size  <= SC_CS;
        r_mis   <= w_in_mis;
      end
      if (r_state == RDWAIT) r_merged <= w_merged;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (w_in_mis)                   w_next = DONE;
          else if (w_in_half || w_in_byte) w_next = READ;
          else                             w_next = WRITE;
        end
      end
      READ: begin
        mem_re   = 1'b1;
        mem_addr = w_addr_al;
        w_next   = RDWAIT;
      end
      RDWAIT: begin
        w_next = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = w_addr_al;
        mem_wdata = w_rmw ? r_merged : r_wdata;
        w_next    = DONE;
      end
      DONE: begin
        done   = 1'b1;
        err    = r_mis;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
